// File: rtl/axi_dma_rd_streamer.sv
// axi_dma_rd_streamer: read-side AXI4 burst generator for the DMA.
// Takes a descriptor (source address, byte count, INCR/FIXED mode), splits it
// into legal AR bursts, limits bursts in flight by snooping R-channel last
// beats, and reports completion or descriptor errors back to the CSR block.
// Optional feature macro: AXI_DMA_RD_PERF_EN enables the perf_cycles_o
// busy-cycle counter; when undefined perf_cycles_o is tied to zero.
module axi_dma_rd_streamer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_BYTES_WIDTH = 32,
    parameter int MAX_BEATS       = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       desc_valid_i,
    output logic                       desc_ready_o,
    input  logic [ADDR_WIDTH-1:0]      desc_src_addr_i,
    input  logic [NUM_BYTES_WIDTH-1:0] desc_num_bytes_i,
    input  logic                       desc_rd_mode_i,
    input  logic                       abort_i,
    output logic                       arvalid_o,
    input  logic                       arready_i,
    output logic [ADDR_WIDTH-1:0]      araddr_o,
    output logic [7:0]                 arlen_o,
    output logic [2:0]                 arsize_o,
    output logic [1:0]                 arburst_o,
    input  logic                       rvalid_i,
    input  logic                       rready_i,
    input  logic                       rlast_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o,
    output logic [ADDR_WIDTH-1:0]      error_addr_o,
    output logic [31:0]                perf_cycles_o
);

    localparam int BPB  = DATA_WIDTH / 8;
    localparam int SIZE = $clog2(BPB);
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DRAIN} state_t;

    state_t                     state, state_next;
    logic [ADDR_WIDTH-1:0]      cur_addr;
    logic [NUM_BYTES_WIDTH-1:0] beats_rem;
    logic                       rd_mode;
    logic                       abort_pend;
    logic [OW-1:0]              outstanding;
    logic [ADDR_WIDTH-1:0]      araddr_q;
    logic [7:0]                 arlen_q;
    logic [1:0]                 arburst_q;
    logic                       done_q;
    logic                       error_q;
    logic [ADDR_WIDTH-1:0]      error_addr_q;

    logic                       accept;
    logic                       desc_bad;
    logic                       ar_hs;
    logic                       r_last_hs;
    logic                       abort_any;
    logic                       at_limit;
    logic                       load_ar;
    logic [12:0]                page_bytes;
    logic [NUM_BYTES_WIDTH-1:0] page_beats;
    logic [NUM_BYTES_WIDTH-1:0] calc_len;
    logic [NUM_BYTES_WIDTH-1:0] issued_len;
    logic [NUM_BYTES_WIDTH-1:0] beats_after;

    assign accept      = (state == IDLE) && desc_valid_i;
    assign desc_bad    = ((desc_src_addr_i & ADDR_WIDTH'(BPB - 1)) != '0) ||
                         ((desc_num_bytes_i & NUM_BYTES_WIDTH'(BPB - 1)) != '0) ||
                         (desc_num_bytes_i == '0);
    assign ar_hs       = (state == ISSUE) && arready_i;
    assign r_last_hs   = rvalid_i && rready_i && rlast_i && (outstanding != '0);
    assign abort_any   = abort_i || abort_pend;
    assign at_limit    = (outstanding == OW'(MAX_OUTSTANDING));
    assign load_ar     = (state == CALC) && !abort_any && !at_limit;
    assign page_bytes  = 13'd4096 - {1'b0, cur_addr[11:0]};
    assign page_beats  = NUM_BYTES_WIDTH'(page_bytes >> SIZE);
    assign issued_len  = NUM_BYTES_WIDTH'(arlen_q) + NUM_BYTES_WIDTH'(1);
    assign beats_after = beats_rem - issued_len;

    // Burst length: clip to remaining beats, then the mode-specific burst cap
    // and, for INCR, the distance to the next 4 KB page boundary.
    always_comb begin
        calc_len = beats_rem;
        if (rd_mode) begin
            if (calc_len > NUM_BYTES_WIDTH'(16)) calc_len = NUM_BYTES_WIDTH'(16);
        end else begin
            if (calc_len > NUM_BYTES_WIDTH'(MAX_BEATS)) calc_len = NUM_BYTES_WIDTH'(MAX_BEATS);
            if (calc_len > page_beats) calc_len = page_beats;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic; an abort stops further bursts but never drops an AR already presented.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept && !desc_bad) state_next = CALC;
            CALC:  begin
                if (abort_any)     state_next = DRAIN;
                else if (!at_limit) state_next = ISSUE;
            end
            ISSUE: if (ar_hs) state_next = ((beats_after != '0) && !abort_any) ? CALC : DRAIN;
            DRAIN: if (outstanding == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        desc_ready_o = (state == IDLE);
        busy_o       = (state != IDLE);
        arvalid_o    = (state == ISSUE);
    end

    // Descriptor latch, burst bookkeeping, AR payload registers and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr     <= '0;
            beats_rem    <= '0;
            rd_mode      <= 1'b0;
            abort_pend   <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arburst_q    <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            error_addr_q <= '0;
        end else begin
            done_q  <= (state == DRAIN) && (outstanding == '0);
            error_q <= accept && desc_bad;
            if (accept) begin
                abort_pend <= 1'b0;
                if (desc_bad) begin
                    error_addr_q <= desc_src_addr_i;
                end else begin
                    cur_addr  <= desc_src_addr_i;
                    beats_rem <= desc_num_bytes_i >> SIZE;
                    rd_mode   <= desc_rd_mode_i;
                end
            end else if ((state != IDLE) && abort_i) begin
                abort_pend <= 1'b1;
            end
            if (load_ar) begin
                araddr_q  <= cur_addr;
                arlen_q   <= 8'(calc_len - NUM_BYTES_WIDTH'(1));
                arburst_q <= rd_mode ? 2'b00 : 2'b01;
            end
            if (ar_hs) begin
                beats_rem <= beats_after;
                if (!rd_mode) cur_addr <= cur_addr + (ADDR_WIDTH'(issued_len) << SIZE);
            end
        end
    end

    // Bursts in flight: up on AR handshake, down on a snooped last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({ar_hs, r_last_hs})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign araddr_o     = araddr_q;
    assign arlen_o      = arlen_q;
    assign arsize_o     = 3'(SIZE);
    assign arburst_o    = arburst_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign error_addr_o = error_addr_q;

`ifdef AXI_DMA_RD_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: cleared on a good accept, saturating, held while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       perf_q <= '0;
        else if (accept && !desc_bad)                     perf_q <= '0;
        else if ((state != IDLE) && (perf_q != 32'hFFFF_FFFF)) perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_axi_dma_rd_streamer.sv
// tb_axi_dma_rd_streamer: scoreboard bench for axi_dma_rd_streamer.
// Expected AR bursts are queued when each descriptor is driven and checked as
// the DUT issues them; a simple R-channel responder returns one last beat per burst.
module tb_axi_dma_rd_streamer;

    localparam int MAXO = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } ar_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        desc_valid_i = 1'b0;
    logic        desc_ready_o;
    logic [31:0] desc_src_addr_i = '0;
    logic [31:0] desc_num_bytes_i = '0;
    logic        desc_rd_mode_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        arvalid_o;
    logic        arready_i = 1'b1;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic        rvalid_i = 1'b0;
    logic        rready_i = 1'b1;
    logic        rlast_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [31:0] error_addr_o;
    logic [31:0] perf_cycles_o;

    ar_t exp_q[$];
    ar_t exp_ar;
    int  pass_count = 0;
    int  check_count = 0;
    int  done_count = 0;
    int  error_count = 0;
    int  ar_count = 0;
    int  model_out = 0;
    int  busy_cycles = 0;
    int  r_delay = 0;
    logic auto_r = 1'b1;

    axi_dma_rd_streamer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_BYTES_WIDTH(32),
        .MAX_BEATS(256), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_src_addr_i(desc_src_addr_i), .desc_num_bytes_i(desc_num_bytes_i),
        .desc_rd_mode_i(desc_rd_mode_i), .abort_i(abort_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .rvalid_i(rvalid_i), .rready_i(rready_i), .rlast_i(rlast_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .error_addr_o(error_addr_o), .perf_cycles_o(perf_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Mid-cycle monitor: scores AR handshakes and tallies status pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (arvalid_o && arready_i) begin
                ar_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ar", {32'd0, araddr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_ar = exp_q.pop_front();
                    checkOutput("araddr", araddr_o, exp_ar.addr);
                    checkOutput("arlen", arlen_o, exp_ar.len);
                    checkOutput("arburst", arburst_o, exp_ar.burst);
                    checkOutput("arsize", arsize_o, 3'd2);
                end
                checkOutput("outstanding_limit", (model_out < MAXO), 1);
                model_out++;
            end
            if (done_o) begin
                done_count++;
                checkOutput("done_after_rlasts", model_out, 0);
            end
            if (error_o) error_count++;
            if (busy_o) busy_cycles++;
        end
    end

    // R-channel responder: one last beat per outstanding burst after a short delay.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rvalid_i = 1'b0;
            rlast_i  = 1'b0;
            if (auto_r && model_out > 0) begin
                if (r_delay >= 6) begin
                    rvalid_i = 1'b1;
                    rlast_i  = 1'b1;
                    model_out--;
                    r_delay = 0;
                end else begin
                    r_delay++;
                end
            end else begin
                r_delay = 0;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushAr(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        ar_t e;
        e.addr = addr;
        e.len = len;
        e.burst = burst;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] nbytes, input logic mode);
        int t;
        t = 0;
        while (!desc_ready_o && t < 200) begin
            tick(1);
            t++;
        end
        checkOutput("ready_timeout", desc_ready_o, 1);
        busy_cycles = 0;
        desc_src_addr_i  = src;
        desc_num_bytes_i = nbytes;
        desc_rd_mode_i   = mode;
        desc_valid_i     = 1'b1;
        tick(1);
        desc_valid_i = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int d0;
        int t;
        d0 = done_count;
        t = 0;
        while (done_count == d0 && t < budget) begin
            tick(1);
            t++;
        end
        checkOutput("done_timeout", (done_count != d0), 1);
    endtask

    task automatic closeCase(input string tag, input int done0, input int ar0, input int n_ar);
        tick(3);
        checkOutput({tag, "_done_pulses"}, done_count - done0, 1);
        checkOutput({tag, "_ar_count"}, ar_count - ar0, n_ar);
        checkOutput({tag, "_queue_empty"}, exp_q.size(), 0);
        checkOutput({tag, "_ready"}, desc_ready_o, 1);
        checkOutput({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        int d0;
        int a0;
        int e0;

        // Reset values
        #12;
        checkOutput("rst_desc_ready", desc_ready_o, 1);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_arvalid", arvalid_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_error", error_o, 0);
        checkOutput("rst_araddr", araddr_o, 0);
        checkOutput("rst_arsize", arsize_o, 3'd2);
        checkOutput("rst_perf", perf_cycles_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // Single INCR burst, with accept-to-arvalid latency
        d0 = done_count; a0 = ar_count;
        pushAr(32'h1000, 8'd3, 2'b01);
        applyStimulus(32'h1000, 32'd16, 1'b0);
        checkOutput("t1_calc_busy", busy_o, 1);
        checkOutput("t1_calc_arvalid", arvalid_o, 0);
        tick(1);
        checkOutput("t1_issue_arvalid", arvalid_o, 1);
        waitDone(100);
        closeCase("t1", d0, a0, 1);

        // INCR crossing a 4 KB page
        d0 = done_count; a0 = ar_count;
        pushAr(32'h0FF0, 8'd3, 2'b01);
        pushAr(32'h1000, 8'd11, 2'b01);
        applyStimulus(32'h0FF0, 32'd64, 1'b0);
        waitDone(200);
        closeCase("t2", d0, a0, 2);

        // Max-length bursts, limited by the outstanding cap
        d0 = done_count; a0 = ar_count;
        pushAr(32'h0000, 8'd255, 2'b01);
        pushAr(32'h0400, 8'd255, 2'b01);
        pushAr(32'h0800, 8'd255, 2'b01);
        pushAr(32'h0C00, 8'd255, 2'b01);
        applyStimulus(32'h0, 32'd4096, 1'b0);
        waitDone(300);
        closeCase("t3", d0, a0, 4);

        // FIXED bursts capped at 16 beats; a new descriptor while busy is ignored
        d0 = done_count; a0 = ar_count;
        pushAr(32'h2000, 8'd15, 2'b00);
        pushAr(32'h2000, 8'd3, 2'b00);
        applyStimulus(32'h2000, 32'd80, 1'b1);
        desc_src_addr_i  = 32'h5000;
        desc_num_bytes_i = 32'd64;
        desc_rd_mode_i   = 1'b0;
        desc_valid_i     = 1'b1;
        tick(3);
        desc_valid_i = 1'b0;
        waitDone(200);
        closeCase("t4", d0, a0, 2);

        // Descriptor errors: misaligned address, zero length, ragged length
        e0 = error_count; a0 = ar_count; d0 = done_count;
        applyStimulus(32'h1002, 32'd16, 1'b0);
        checkOutput("err1_pulse", error_o, 1);
        tick(3);
        checkOutput("err1_count", error_count - e0, 1);
        checkOutput("err1_addr", error_addr_o, 32'h1002);
        checkOutput("err1_busy", busy_o, 0);
        applyStimulus(32'h3000, 32'd0, 1'b0);
        tick(3);
        checkOutput("err2_count", error_count - e0, 2);
        checkOutput("err2_addr", error_addr_o, 32'h3000);
        applyStimulus(32'h3400, 32'd6, 1'b0);
        tick(3);
        checkOutput("err3_count", error_count - e0, 3);
        checkOutput("err3_addr", error_addr_o, 32'h3400);
        checkOutput("err_no_ar", ar_count - a0, 0);
        checkOutput("err_no_done", done_count - d0, 0);

        // Abort in IDLE is ignored
        abort_i = 1'b1;
        tick(3);
        checkOutput("idle_abort_busy", busy_o, 0);
        abort_i = 1'b0;

        // Abort during a stalled ISSUE
        d0 = done_count; a0 = ar_count;
        arready_i = 1'b0;
        pushAr(32'h0000, 8'd255, 2'b01);
        applyStimulus(32'h0, 32'd2048, 1'b0);
        tick(4);
        abort_i = 1'b1;
        tick(3);
        checkOutput("abort_arvalid_held", arvalid_o, 1);
        checkOutput("abort_araddr_held", araddr_o, 32'h0);
        checkOutput("abort_arlen_held", arlen_o, 8'd255);
        arready_i = 1'b1;
        waitDone(200);
        abort_i = 1'b0;
        closeCase("t6", d0, a0, 1);
`ifdef AXI_DMA_RD_PERF_EN
        checkOutput("perf_cycles", perf_cycles_o, busy_cycles);
        tick(4);
        checkOutput("perf_held", perf_cycles_o, busy_cycles);
`else
        checkOutput("perf_tied_zero", perf_cycles_o, 0);
`endif

        // Async reset mid-transfer, then a clean descriptor
        auto_r = 1'b0;
        pushAr(32'h0000, 8'd255, 2'b01);
        pushAr(32'h0400, 8'd255, 2'b01);
        applyStimulus(32'h0, 32'd4096, 1'b0);
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_ready", desc_ready_o, 1);
        checkOutput("arst_busy", busy_o, 0);
        checkOutput("arst_arvalid", arvalid_o, 0);
        exp_q.delete();
        model_out = 0;
        tick(2);
        rst_n = 1'b1;
        auto_r = 1'b1;
        tick(1);
        d0 = done_count; a0 = ar_count;
        pushAr(32'h1000, 8'd3, 2'b01);
        applyStimulus(32'h1000, 32'd16, 1'b0);
        waitDone(100);
        closeCase("post_rst", d0, a0, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("%0d/%0d checks passed", pass_count, check_count + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
